// File: rtl/instr_fetch_buffer.sv
// Fetch stage between the program counter and decode: issues each accepted PC to a
// 1-cycle synchronous instruction memory and queues {instruction, PC} in a small FIFO.
module instr_fetch_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        pc_in,
    input  logic                         pc_valid,
    output logic                         pc_stall,
    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic [DATA_WIDTH-1:0]        imem_rdata,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        instr_out,
    output logic [ADDR_WIDTH-1:0]        instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_v_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;

    logic [CNT_W:0]        occupancy;
    logic                  accept;
    logic                  push;
    logic                  pop;

    always_comb begin
        // An in-flight fetch already owns a FIFO slot, so it counts toward the stall.
        occupancy   = {1'b0, count_q} + (CNT_W+1)'(inflight_v_q);
        pc_stall    = occupancy >= (CNT_W+1)'(DEPTH);
        accept      = pc_valid & ~pc_stall & ~flush;
        imem_req    = accept;
        imem_addr   = pc_in;

        instr_valid = (count_q != '0) & ~flush;
        push        = inflight_v_q & ~flush;
        pop         = instr_valid & instr_ready;
        instr_out   = instr_valid ? data_mem[rd_ptr_q] : '0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    assign count = count_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else if (flush) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_v_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_v_q  <= accept;
            if (accept) begin
                inflight_pc_q <= pc_in;
            end
        end
    end

    // NOTE: storage has no reset; entries are only observed while count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a queue-based model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic.
module tb_instr_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: word i holds 0xA0 + i.
    function automatic logic [31:0] memf(input logic [31:0] addr);
        return 32'hA0 + (addr >> 2);
    endfunction

    // Synchronous memory: data only meaningful the cycle after a request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? memf(imem_addr) : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: list of buffered fetches plus at most one outstanding fetch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_inf_v  = 1'b0;
    logic [31:0] m_inf_pc = '0;

    always @(negedge clk) begin
        logic stall_e, acc_e, val_e;
        ent_t head;
        stall_e = (mq.size() + (m_inf_v ? 1 : 0)) >= DEPTH;
        acc_e   = pc_valid && !stall_e && !flush;
        val_e   = (mq.size() != 0) && !flush;
        head    = (mq.size() != 0) ? mq[0] : '0;
        if (!rst) begin
            if (!flush) check("m_pc_stall", pc_stall, stall_e);
            check("m_imem_req",    imem_req,    acc_e);
            check("m_imem_addr",   imem_addr,   pc_in);
            check("m_instr_valid", instr_valid, val_e);
            check("m_instr_out",   instr_out,   val_e ? head.data : 32'h0);
            check("m_instr_pc",    instr_pc,    val_e ? head.pc   : 32'h0);
            check("m_count",       count,       mq.size());
        end
        if (rst) begin
            mq.delete();
            m_inf_v  = 1'b0;
            m_inf_pc = '0;
        end else if (flush) begin
            mq.delete();
            m_inf_v = 1'b0;
        end else begin
            if (val_e && instr_ready) void'(mq.pop_front());
            if (m_inf_v) mq.push_back('{pc: m_inf_pc, data: memf(m_inf_pc)});
            m_inf_v = acc_e;
            if (acc_e) m_inf_pc = pc_in;
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
        pc_valid    = v;
        pc_in       = pc;
        instr_ready = r;
        flush       = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // 1: streaming with decode always ready
        do_reset();
        drive(1, 32'h0, 1, 0); #1;
        check("t1_rst_valid", instr_valid, 0);
        check("t1_rst_count", count, 0);
        check("t1_rst_stall", pc_stall, 0);
        check("t1_rst_out",   instr_out, 0);
        check("t1_req",       imem_req, 1);
        tick();
        drive(1, 32'h4, 1, 0); #1; check("t1_lat_valid", instr_valid, 0); tick();
        drive(1, 32'h8, 1, 0); #1;
        check("t1_first_valid", instr_valid, 1);
        check("t1_first_pc", instr_pc, 32'h0);
        check("t1_first_out", instr_out, 32'hA0);
        tick();
        drive(1, 32'hC, 1, 0); #1;
        check("t1_pc4", instr_pc, 32'h4); check("t1_out4", instr_out, 32'hA1);
        check("t1_count", count, 1);
        tick();
        drive(0, 32'h0, 1, 0); #1; check("t1_pc8", instr_pc, 32'h8); check("t1_out8", instr_out, 32'hA2); tick();
        drive(0, 32'h0, 1, 0); #1; check("t1_pcC", instr_pc, 32'hC); check("t1_outC", instr_out, 32'hA3); tick();
        drive(0, 32'h0, 1, 0); #1; check("t1_empty", instr_valid, 0); tick();

        // 2: fill to capacity with decode stalled, then drain
        do_reset();
        pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            drive(1, pc, 0, 0); #1; check("t2_fill_stall", pc_stall, 0);
            pc += 4;
            tick();
        end
        drive(1, pc, 0, 0); #1; check("t2_full_stall", pc_stall, 1); check("t2_count3", count, 3); tick();
        drive(1, pc, 0, 0); #1; check("t2_stall4", pc_stall, 1); check("t2_count4", count, 4); tick();
        drive(1, pc, 1, 0); #1;
        check("t2_drain0", instr_pc, 32'h0); check("t2_req_blocked", imem_req, 0);
        tick();
        drive(1, pc, 1, 0); #1;
        check("t2_drain4", instr_pc, 32'h4); check("t2_unstall", pc_stall, 0);
        check("t2_req10", imem_req, 1); check("t2_addr10", imem_addr, 32'h10);
        tick();
        drive(0, 32'h0, 1, 0); #1; check("t2_drain8", instr_pc, 32'h8); tick();
        drive(0, 32'h0, 1, 0); #1; check("t2_drainC", instr_pc, 32'hC); tick();
        drive(0, 32'h0, 1, 0); #1; check("t2_pc10", instr_pc, 32'h10); check("t2_out10", instr_out, 32'hA4); tick();
        drive(0, 32'h0, 1, 0); #1; check("t2_done", instr_valid, 0); tick();

        // 3: flush with two buffered entries and one fetch in flight
        do_reset();
        drive(1, 32'h0, 0, 0); tick();
        drive(1, 32'h4, 0, 0); tick();
        drive(1, 32'h8, 0, 0); tick();
        drive(1, 32'h100, 0, 1); #1;
        check("t3_pre_count", count, 2); check("t3_flush_req", imem_req, 0);
        check("t3_flush_valid", instr_valid, 0);
        tick();
        drive(1, 32'h100, 1, 0); #1;
        check("t3_post_count", count, 0); check("t3_post_valid", instr_valid, 0);
        check("t3_post_req", imem_req, 1);
        tick();
        drive(0, 32'h0, 1, 0); #1; check("t3_no_stale", instr_valid, 0); tick();
        drive(0, 32'h0, 1, 0); #1;
        check("t3_new_valid", instr_valid, 1); check("t3_new_pc", instr_pc, 32'h100);
        check("t3_new_out", instr_out, 32'hE0);
        tick();
        drive(0, 32'h0, 1, 0); tick();

        // 4: push and pop together at count 3, crossing pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(i * 4), 0, 0); tick();
        end
        drive(1, 32'h210, 1, 0); #1;
        check("t4_count3", count, 3); check("t4_stall", pc_stall, 1); check("t4_head", instr_pc, 32'h200);
        tick();
        drive(1, 32'h210, 1, 0); #1;
        check("t4_count_same", count, 3); check("t4_head204", instr_pc, 32'h204);
        tick();
        drive(0, 32'h0, 1, 0); #1; check("t4_head208", instr_pc, 32'h208); tick();
        drive(0, 32'h0, 1, 0); #1; check("t4_head20C", instr_pc, 32'h20C); tick();
        drive(0, 32'h0, 1, 0); #1;
        check("t4_wrap_pc", instr_pc, 32'h210); check("t4_wrap_out", instr_out, 32'h124);
        tick();
        drive(0, 32'h0, 1, 0); tick();

        // 5: reset in the middle of activity
        do_reset();
        drive(1, 32'h300, 0, 0); tick();
        drive(1, 32'h304, 0, 0); tick();
        drive(1, 32'h308, 0, 0); tick();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0); #1; check("t5_pre_count", count, 2); tick();
        rst = 1'b0;
        drive(1, 32'h400, 1, 0); #1;
        check("t5_valid", instr_valid, 0); check("t5_out", instr_out, 0);
        check("t5_pc", instr_pc, 0); check("t5_stall", pc_stall, 0);
        check("t5_count", count, 0); check("t5_req", imem_req, 1);
        tick();

        // 6: alternating requests with random decode readiness
        do_reset();
        pc = 32'h1000;
        for (int i = 0; i < 200; i++) begin
            drive(i % 2 == 0, pc, 1'($urandom), 0); #1;
            check("t6_count_range", count <= DEPTH, 1);
            if (imem_req) pc += 4;
            tick();
        end

        // 7: fully random traffic including flush and reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(63) == 0);
            drive(1'($urandom), 32'($urandom) & 32'hFFFC, ($urandom_range(3) != 0),
                  ($urandom_range(15) == 0));
            tick();
        end
        rst = 1'b0;
        drive(0, 32'h0, 1, 0);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
